mem_preload_engine: RTL
=======================

Name: mem_preload_engine

Overview:
Parametrised backdoor memory loader and checker for the NES DV environment. It supersedes the one-shot whole-array override with a command-driven engine. The engine streams bytes into any address window (LOAD), fills a window with a constant (FILL), or compares a window against a reference stream (VERIFY). It sits between the testbench stimulus layer and the DUT memory's secondary port, and operates only while the CPU is held.

Parameters:
DATA_WIDTH, 8, memory word width (REG_WIDTH)
ADDR_WIDTH, 16, memory address width; depth = 2**ADDR_WIDTH
LEN_WIDTH, ADDR_WIDTH+1, command length width, so a full-depth window is representable

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cpu_halted  in  1  CPU held; commands are legal only while high
cmd_valid  in  1  command request
cmd_ready  out  1  engine accepts command (high only in IDLE)
cmd_mode  in  2  0=LOAD, 1=VERIFY, 2=FILL, 3=reserved
cmd_base  in  ADDR_WIDTH  first address
cmd_len  in  LEN_WIDTH  word count
cmd_fill  in  DATA_WIDTH  FILL constant
s_valid  in  1  data stream valid (LOAD/VERIFY)
s_ready  out  1  data stream ready
s_data  in  DATA_WIDTH  data word
mem_we  out  1  memory write strobe
mem_re  out  1  memory read strobe
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  write data
mem_rdata  in  DATA_WIDTH  read data, valid exactly 1 cycle after mem_re
busy  out  1  command in progress
done  out  1  one-cycle pulse on normal completion
err  out  1  one-cycle pulse on rejected or aborted command
mismatch_cnt  out  LEN_WIDTH  VERIFY mismatches, saturating
first_mismatch_addr  out  ADDR_WIDTH  address of first VERIFY mismatch
mismatch_seen  out  1  at least one mismatch in the last VERIFY

Behaviour:
- Reset: all outputs 0 except cmd_ready=1. FSM goes to IDLE. Reset mid-command abandons it with no done/err.
- States: IDLE, LOAD, FILL, VERIFY, DRAIN, FINISH.
- IDLE: on cmd_valid&&cmd_ready, latch base, len, mode and fill.
  - cpu_halted=0 or mode=3 -> err pulse next cycle, stay IDLE, no memory access.
  - len=0 -> FINISH (done next cycle, no access).
  - Otherwise go to the mode state. VERIFY also clears the mismatch outputs on acceptance.
- Address: mem_addr = base + index, modulo 2**ADDR_WIDTH, so wrap from 0xFFFF to 0x0000 is legal.
- LOAD: s_ready=1. Each s_valid&&s_ready drives mem_we=1, mem_addr and mem_wdata=s_data in that same cycle (combinational from the handshake). After the len-th write -> FINISH.
- FILL: mem_we=1 every cycle with mem_wdata=fill, one word per cycle, len cycles, then FINISH. s_ready=0.
- VERIFY:
  - Each handshake asserts mem_re with the current address and registers the expected word and address.
  - The next cycle compares mem_rdata with the expected word. On mismatch, increment mismatch_cnt (saturating at all-ones). On the first mismatch only, capture first_mismatch_addr and set mismatch_seen.
  - Throughput is 1 word/cycle; compares overlap new reads.
  - After the last read -> DRAIN (one cycle, final compare) -> FINISH.
- FINISH: done=1 for one cycle -> IDLE. busy=1 in every state except IDLE.
- Abort: cpu_halted falling while busy causes the following:
  - Any pending VERIFY compare is discarded.
  - No further memory strobes are issued.
  - err pulses the next cycle, then IDLE.
  - Writes already issued stand.
- s_valid gaps stall the index; the engine has no timeout.
- mem_we and mem_re are never both high in the same cycle.
- mismatch outputs hold until the next VERIFY is accepted.

Decomposition:
- Package mem_preload_pkg holds:
  - the mode enum (LOAD/VERIFY/FILL/RSVD)
  - the FSM state enum
  - default width constants tied to REG_WIDTH and MEM_DEPTH
- One sub-module, mem_preload_cmp: a registered expected/address pipeline stage with a saturating mismatch counter and first-address capture. The FSM and address generator stay in the top module.

Test Plan:
- LOAD base=0x8000, len=4, data 0xA9,0x01,0x8D,0x00, cpu_halted=1 -> four mem_we at 0x8000..0x8003 with those data, done 1 cycle after the last write, busy low after.
- FILL base=0xFFFE, len=4, fill=0xEA -> writes at 0xFFFE, 0xFFFF, 0x0000, 0x0001, all 0xEA, one per cycle.
- VERIFY base=0x0010, len=3, stream 0x11,0x22,0x33, model returns 0x11,0x20,0x30 -> mismatch_cnt=2, first_mismatch_addr=0x0011, mismatch_seen=1, done after DRAIN.
- Command with cpu_halted=0 -> err pulse, no mem_we/mem_re. Command with len=0 -> done next cycle, no access.
- LOAD len=8 with cpu_halted dropped after 3 writes -> exactly 3 writes, err pulse, no done, cmd_ready=1 next cycle.
- VERIFY with s_valid toggling every other cycle, then reset asserted mid-command -> compares are correct across gaps; after reset all outputs are 0, cmd_ready=1, and there is no done/err.

Source files
------------

// File: rtl/mem_preload_pkg.sv
// Shared types and default widths for the backdoor memory preload engine.
package mem_preload_pkg;

    localparam int unsigned REG_WIDTH      = 8;
    localparam int unsigned MEM_DEPTH      = 65536;
    localparam int unsigned MEM_ADDR_WIDTH = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {
        MODE_LOAD   = 2'd0,
        MODE_VERIFY = 2'd1,
        MODE_FILL   = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FILL,
        S_VERIFY,
        S_DRAIN,
        S_FINISH
    } state_e;

endpackage

// File: rtl/mem_preload_cmp.sv
// VERIFY compare stage: registers expected word/address on each read and
// compares against read data one cycle later.
module mem_preload_cmp #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  flush,
    input  logic                  capture,
    input  logic [DATA_WIDTH-1:0] exp_data,
    input  logic [ADDR_WIDTH-1:0] exp_addr,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [LEN_WIDTH-1:0]  mismatch_cnt,
    output logic [ADDR_WIDTH-1:0] first_mismatch_addr,
    output logic                  mismatch_seen
);

    logic                  pend_q;
    logic [DATA_WIDTH-1:0] exp_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  miss;

    assign miss = pend_q && !flush && (rdata != exp_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q              <= 1'b0;
            exp_q               <= '0;
            addr_q              <= '0;
            mismatch_cnt        <= '0;
            first_mismatch_addr <= '0;
            mismatch_seen       <= 1'b0;
        end else begin
            pend_q <= capture && !flush;
            if (capture) begin
                exp_q  <= exp_data;
                addr_q <= exp_addr;
            end
            if (clear) begin
                mismatch_cnt        <= '0;
                first_mismatch_addr <= '0;
                mismatch_seen       <= 1'b0;
            end else if (miss) begin
                if (mismatch_cnt != '1)
                    mismatch_cnt <= mismatch_cnt + LEN_WIDTH'(1);
                if (!mismatch_seen) begin
                    mismatch_seen       <= 1'b1;
                    first_mismatch_addr <= addr_q;
                end
            end
        end
    end

endmodule

// File: rtl/mem_preload_engine.sv
// Command-driven backdoor loader/checker: LOAD streams words into a window,
// FILL writes a constant, VERIFY compares a window against a reference stream.
module mem_preload_engine
    import mem_preload_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = REG_WIDTH,
    parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int unsigned LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_halted,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_mode,
    input  logic [ADDR_WIDTH-1:0] cmd_base,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [DATA_WIDTH-1:0] cmd_fill,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [LEN_WIDTH-1:0]  mismatch_cnt,
    output logic [ADDR_WIDTH-1:0] first_mismatch_addr,
    output logic                  mismatch_seen
);

    state_e                state;
    mode_e                 mode_in;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  idx_q;
    logic [LEN_WIDTH-1:0]  idx_next;
    logic [DATA_WIDTH-1:0] fill_q;
    logic [ADDR_WIDTH-1:0] addr_cur;
    logic                  hs;
    logic                  step;
    logic                  last;
    logic                  abort;
    logic                  legal;
    logic                  verify_clear;

    assign mode_in  = mode_e'(cmd_mode);
    assign addr_cur = base_q + idx_q[ADDR_WIDTH-1:0];
    assign idx_next = idx_q + LEN_WIDTH'(1);
    assign last     = (idx_next == len_q);

    // Strobes are gated by cpu_halted so a falling halt issues nothing that cycle.
    assign s_ready = ((state == S_LOAD) || (state == S_VERIFY)) && cpu_halted;
    assign hs      = s_valid && s_ready;
    assign step    = hs || ((state == S_FILL) && cpu_halted);
    assign abort   = !cpu_halted &&
                     ((state == S_LOAD) || (state == S_FILL) ||
                      (state == S_VERIFY) || (state == S_DRAIN));

    assign mem_we    = ((state == S_LOAD) && hs) || ((state == S_FILL) && cpu_halted);
    assign mem_re    = (state == S_VERIFY) && hs;
    assign mem_addr  = (mem_we || mem_re) ? addr_cur : '0;
    assign mem_wdata = mem_we ? ((state == S_FILL) ? fill_q : s_data) : '0;

    assign legal        = cmd_valid && cmd_ready && cpu_halted && (mode_in != MODE_RSVD);
    assign verify_clear = legal && (mode_in == MODE_VERIFY);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            base_q    <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            fill_q    <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        base_q <= cmd_base;
                        len_q  <= cmd_len;
                        fill_q <= cmd_fill;
                        idx_q  <= '0;
                        if (!legal) begin
                            err <= 1'b1;
                        end else begin
                            cmd_ready <= 1'b0;
                            busy      <= 1'b1;
                            if (cmd_len == '0) begin
                                state <= S_FINISH;
                                done  <= 1'b1;
                            end else begin
                                case (mode_in)
                                    MODE_LOAD:   state <= S_LOAD;
                                    MODE_FILL:   state <= S_FILL;
                                    default:     state <= S_VERIFY;
                                endcase
                            end
                        end
                    end
                end
                S_LOAD, S_FILL, S_VERIFY: begin
                    if (abort) begin
                        state     <= S_IDLE;
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end else if (step) begin
                        idx_q <= idx_next;
                        if (last) begin
                            if (state == S_VERIFY) begin
                                state <= S_DRAIN;
                            end else begin
                                state <= S_FINISH;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        state     <= S_IDLE;
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end else begin
                        state <= S_FINISH;
                        done  <= 1'b1;
                    end
                end
                S_FINISH: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    mem_preload_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_cmp (
        .clk                 (clk),
        .reset               (reset),
        .clear               (verify_clear),
        .flush               (abort),
        .capture             (mem_re),
        .exp_data            (s_data),
        .exp_addr            (addr_cur),
        .rdata               (mem_rdata),
        .mismatch_cnt        (mismatch_cnt),
        .first_mismatch_addr (first_mismatch_addr),
        .mismatch_seen       (mismatch_seen)
    );

endmodule
